// File: rtl/nios_cpu_onchip_memory_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slaves (s1, s2).
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   clken, reset_req       : global enable; clken=0 or reset_req=1 freezes both ports
//   sN_address/chipselect/read/write/byteenable/writedata : Avalon-MM requests
//   sN_readdata/readdatavalid : read return after READ_LATENCY enabled cycles
//   sN_waitrequest         : combinational stall (scrub in progress or cycle disabled)
// After reset an optional scrub sequencer fills every word with SCRUB_VALUE
// before either port is released.
module nios_cpu_onchip_memory_dp #(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 11,
  parameter int unsigned           READ_LATENCY   = 1,
  parameter bit                    SCRUB_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] SCRUB_VALUE    = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LANES = DATA_WIDTH / 8;
  localparam int unsigned LAT   = (READ_LATENCY >= 2) ? 2 : 1;

  typedef enum logic {SCRUB, READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    scrub_we;
  logic                    en;
  logic                    ready;
  logic                    s1_wr_acc, s1_rd_acc, s2_wr_acc, s2_rd_acc;
  logic [DATA_WIDTH-1:0]   s1_rd_word, s2_rd_word;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [LAT-1:0]          s1_vld_q, s2_vld_q;
  logic [DATA_WIDTH-1:0]   s1_dat_q [LAT];
  logic [DATA_WIDTH-1:0]   s2_dat_q [LAT];

  // Enable, port release and request acceptance
  assign en             = clken & ~reset_req;
  assign ready          = reset_n & en & (state_q == READY);
  assign s1_waitrequest = ~ready;
  assign s2_waitrequest = ~ready;
  assign s1_wr_acc      = ready & s1_chipselect & s1_write;
  assign s1_rd_acc      = ready & s1_chipselect & s1_read & ~s1_write;
  assign s2_wr_acc      = ready & s2_chipselect & s2_write;
  assign s2_rd_acc      = ready & s2_chipselect & s2_read & ~s2_write;

  // Scrub FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SCRUB_ON_RESET ? SCRUB : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scrub FSM next state: one word per enabled cycle, counter stops at the last word
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    scrub_we = 1'b0;
    if (state_q == SCRUB && en) begin
      scrub_we = 1'b1;
      if (&cnt_q) state_d = READY;
      else        cnt_d   = cnt_q + ADDR_WIDTH'(1);
    end
  end

  // Array writes; s1 is applied last so it wins lanes both ports enable
  always_ff @(posedge clk) begin
    if (scrub_we) mem[cnt_q] <= SCRUB_VALUE;
    for (int i = 0; i < LANES; i++) begin
      if (s2_wr_acc && s2_byteenable[i]) mem[s2_address][i*8 +: 8] <= s2_writedata[i*8 +: 8];
      if (s1_wr_acc && s1_byteenable[i]) mem[s1_address][i*8 +: 8] <= s1_writedata[i*8 +: 8];
    end
  end

  // Read words with the other port's same-cycle write merged in (new-data RDW)
  always_comb begin
    s1_rd_word = mem[s1_address];
    s2_rd_word = mem[s2_address];
    for (int i = 0; i < LANES; i++) begin
      if (s2_wr_acc && (s2_address == s1_address) && s2_byteenable[i])
        s1_rd_word[i*8 +: 8] = s2_writedata[i*8 +: 8];
      if (s1_wr_acc && (s1_address == s2_address) && s1_byteenable[i])
        s2_rd_word[i*8 +: 8] = s1_writedata[i*8 +: 8];
    end
  end

  // s1 read-return pipeline; holds while the cycle is disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q <= '0;
      for (int i = 0; i < LAT; i++) s1_dat_q[i] <= '0;
    end else if (en) begin
      s1_vld_q[0] <= s1_rd_acc;
      if (s1_rd_acc) s1_dat_q[0] <= s1_rd_word;
      for (int i = 1; i < LAT; i++) begin
        s1_vld_q[i] <= s1_vld_q[i-1];
        s1_dat_q[i] <= s1_dat_q[i-1];
      end
    end
  end

  // s2 read-return pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_vld_q <= '0;
      for (int i = 0; i < LAT; i++) s2_dat_q[i] <= '0;
    end else if (en) begin
      s2_vld_q[0] <= s2_rd_acc;
      if (s2_rd_acc) s2_dat_q[0] <= s2_rd_word;
      for (int i = 1; i < LAT; i++) begin
        s2_vld_q[i] <= s2_vld_q[i-1];
        s2_dat_q[i] <= s2_dat_q[i-1];
      end
    end
  end

  // Valid is masked in disabled cycles so a held return is presented exactly once
  assign s1_readdata      = s1_dat_q[LAT-1];
  assign s1_readdatavalid = s1_vld_q[LAT-1] & en;
  assign s2_readdata      = s2_dat_q[LAT-1];
  assign s2_readdatavalid = s2_vld_q[LAT-1] & en;

endmodule

// File: tb/tb_nios_cpu_onchip_memory_dp.sv
// Bench for nios_cpu_onchip_memory_dp: two instances (READ_LATENCY 1 and 2) share
// one stimulus stream and are checked against a word-array reference model.
module tb_nios_cpu_onchip_memory_dp;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 11;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct {
    logic [31:0] d;
    int          idx;
  } rd_t;

  logic          clk = 1'b0;
  logic          reset_n, clken, reset_req;
  logic [AW-1:0] s1_address, s2_address;
  logic          s1_chipselect, s1_read, s1_write;
  logic          s2_chipselect, s2_read, s2_write;
  logic [3:0]    s1_byteenable, s2_byteenable;
  logic [DW-1:0] s1_writedata, s2_writedata;

  logic [DW-1:0] a1_rd, a2_rd, b1_rd, b2_rd;
  logic          a1_rv, a2_rv, b1_rv, b2_rv;
  logic          a1_wq, a2_wq, b1_wq, b2_wq;

  logic [31:0]   rdata [2][2];
  logic          rvld  [2][2];
  logic          wreq  [2][2];

  int            n_vec = 0;
  int            n_err = 0;

  // Reference model state
  logic [31:0]   ref_mem [DEPTH];
  rd_t           q1 [$];
  rd_t           q2 [$];
  int            head [2][2];
  int            ecnt = 0;
  bit            scrub_active = 1'b1;
  int            scrub_idx = 0;

  always #5 clk = ~clk;

  nios_cpu_onchip_memory_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_a (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(a1_rd), .s1_readdatavalid(a1_rv), .s1_waitrequest(a1_wq),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(a2_rd), .s2_readdatavalid(a2_rv), .s2_waitrequest(a2_wq)
  );

  nios_cpu_onchip_memory_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) u_b (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(b1_rd), .s1_readdatavalid(b1_rv), .s1_waitrequest(b1_wq),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(b2_rd), .s2_readdatavalid(b2_rv), .s2_waitrequest(b2_wq)
  );

  always_comb begin
    rdata[0][0] = a1_rd; rdata[0][1] = a2_rd; rdata[1][0] = b1_rd; rdata[1][1] = b2_rd;
    rvld[0][0]  = a1_rv; rvld[0][1]  = a2_rv; rvld[1][0]  = b1_rv; rvld[1][1]  = b2_rv;
    wreq[0][0]  = a1_wq; wreq[0][1]  = a2_wq; wreq[1][0]  = b1_wq; wreq[1][1]  = b2_wq;
  end

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int qsize(int p);
    return (p == 0) ? q1.size() : q2.size();
  endfunction

  function automatic rd_t qget(int p, int i);
    return (p == 0) ? q1[i] : q2[i];
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic s1_op(bit rd, bit wr, int addr, logic [31:0] d, logic [3:0] be);
    s1_chipselect = rd | wr; s1_read = rd; s1_write = wr;
    s1_address = AW'(addr); s1_writedata = d; s1_byteenable = be;
  endtask

  task automatic s2_op(bit rd, bit wr, int addr, logic [31:0] d, logic [3:0] be);
    s2_chipselect = rd | wr; s2_read = rd; s2_write = wr;
    s2_address = AW'(addr); s2_writedata = d; s2_byteenable = be;
  endtask

  task automatic idle();
    s1_op(1'b0, 1'b0, 0, 32'h0, 4'h0);
    s2_op(1'b0, 1'b0, 0, 32'h0, 4'h0);
  endtask

  // One clock cycle: check outputs against the model, advance the model, clock the DUTs
  task automatic step();
    bit          en, exp_wait, acc1w, acc1r, acc2w, acc2r;
    int          a1, a2;
    logic [31:0] r1, r2;
    rd_t         e;
    #1;
    en       = clken && !reset_req;
    exp_wait = !reset_n || !en || scrub_active;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("waitrequest L%0d s%0d", lat_of(k), p + 1), 32'(wreq[k][p]), 32'(exp_wait));
        if (!reset_n || !en) begin
          chk($sformatf("readdatavalid idle L%0d s%0d", lat_of(k), p + 1), 32'(rvld[k][p]), 32'd0);
          if (!reset_n)
            chk($sformatf("readdata reset L%0d s%0d", lat_of(k), p + 1), rdata[k][p], 32'd0);
        end else if (head[k][p] < qsize(p) && qget(p, head[k][p]).idx + lat_of(k) == ecnt) begin
          e = qget(p, head[k][p]);
          head[k][p]++;
          chk($sformatf("readdatavalid L%0d s%0d", lat_of(k), p + 1), 32'(rvld[k][p]), 32'd1);
          chk($sformatf("readdata L%0d s%0d", lat_of(k), p + 1), rdata[k][p], e.d);
        end else begin
          chk($sformatf("readdatavalid none L%0d s%0d", lat_of(k), p + 1), 32'(rvld[k][p]), 32'd0);
        end
      end
    end
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        head[k][0] = q1.size();
        head[k][1] = q2.size();
      end
      scrub_active = 1'b1;
      scrub_idx    = 0;
    end else if (en) begin
      if (scrub_active) begin
        ref_mem[scrub_idx] = 32'h0;
        scrub_idx++;
        if (scrub_idx == DEPTH) scrub_active = 1'b0;
      end else begin
        a1 = int'(s1_address);
        a2 = int'(s2_address);
        acc1w = s1_chipselect && s1_write;
        acc1r = s1_chipselect && s1_read && !s1_write;
        acc2w = s2_chipselect && s2_write;
        acc2r = s2_chipselect && s2_read && !s2_write;
        r1 = ref_mem[a1];
        if (acc2w && a2 == a1) r1 = merge(r1, s2_writedata, s2_byteenable);
        r2 = ref_mem[a2];
        if (acc1w && a1 == a2) r2 = merge(r2, s1_writedata, s1_byteenable);
        if (acc1r) q1.push_back('{d: r1, idx: ecnt});
        if (acc2r) q2.push_back('{d: r2, idx: ecnt});
        if (acc2w) ref_mem[a2] = merge(ref_mem[a2], s2_writedata, s2_byteenable);
        if (acc1w) ref_mem[a1] = merge(ref_mem[a1], s1_writedata, s1_byteenable);
      end
      ecnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_scrub();
    for (int i = 0; i < 3 * DEPTH && scrub_active; i++) step();
    chk("scrub completion bound", 32'(scrub_active), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) for (int p = 0; p < 2; p++) head[k][p] = 0;
    reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
    idle();
    @(posedge clk);
    #1;
    step();
    step();

    // Release reset: scrub the whole array, then sweep every address on both ports
    reset_n = 1'b1;
    run_scrub();
    for (int a = 0; a < DEPTH; a++) begin
      s1_op(1'b1, 1'b0, a, 32'h0, 4'h0);
      s2_op(1'b1, 1'b0, DEPTH - 1 - a, 32'h0, 4'h0);
      step();
    end
    idle();
    step(); step(); step();

    // Byte lanes
    s1_op(1'b0, 1'b1, 5, 32'hAABBCCDD, 4'b1111); step();
    s1_op(1'b0, 1'b1, 5, 32'h11223344, 4'b0101); step();
    idle();
    s2_op(1'b1, 1'b0, 5, 32'h0, 4'h0); step();
    idle(); step(); step(); step();

    // Same-address write collision, then mixed-port read-during-write
    s1_op(1'b0, 1'b1, 9, 32'h000000FF, 4'b0001);
    s2_op(1'b0, 1'b1, 9, 32'h12345678, 4'b1111); step();
    s1_op(1'b0, 1'b1, 10, 32'hCAFEF00D, 4'b1111);
    s2_op(1'b1, 1'b0, 10, 32'h0, 4'h0); step();
    s1_op(1'b0, 1'b1, 11, 32'hDEADBEEF, 4'b0110);
    s2_op(1'b1, 1'b0, 11, 32'h0, 4'h0); step();
    idle();
    s1_op(1'b1, 1'b0, 9, 32'h0, 4'h0); step();
    idle(); step(); step(); step();

    // Streaming reads of pre-filled words
    for (int i = 0; i < 8; i++) begin
      s1_op(1'b0, 1'b1, i, 32'(i * 3), 4'hF);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      s1_op(1'b1, 1'b0, i, 32'h0, 4'h0);
      step();
    end
    idle(); step(); step(); step(); step();

    // Two reads in flight across a 3-cycle clken stall
    s1_op(1'b1, 1'b0, 3, 32'h0, 4'h0); step();
    s1_op(1'b1, 1'b0, 4, 32'h0, 4'h0); step();
    idle();
    clken = 1'b0;
    step(); step(); step();
    clken = 1'b1;
    step(); step(); step(); step();

    // Reset with reads in flight: no return may appear
    s1_op(1'b1, 1'b0, 5, 32'h0, 4'h0);
    s2_op(1'b1, 1'b0, 6, 32'h0, 4'h0); step();
    idle();
    reset_n = 1'b0; step();
    reset_n = 1'b1;

    // Scrub with occasional stalls, reset at word 100, then scrub from 0 to completion
    for (int i = 0; i < 1000 && scrub_idx < 100; i++) begin
      clken = ($urandom_range(0, 3) != 0);
      step();
    end
    chk("scrub progress bound", 32'(scrub_idx), 32'd100);
    clken = 1'b1;
    reset_n = 1'b0; step(); step();
    reset_n = 1'b1;
    run_scrub();

    // Randomized traffic on a small address window with stalls
    for (int i = 0; i < 600; i++) begin
      s1_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
            $urandom, 4'($urandom_range(0, 15)));
      s2_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
            $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 7) == 0) s1_chipselect = 1'b0;
      clken     = ($urandom_range(0, 9) != 0);
      reset_req = ($urandom_range(0, 19) == 0);
      step();
    end
    idle();
    clken = 1'b1; reset_req = 1'b0;
    step(); step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
